uart_tx_ctrl: RTL and testbench
===============================

// Module: uart_tx_ctrl
// PURPOSE
//  Sequencing FSM for the UART transmitter. It accepts a frame request, generates bit
//  timing from the system clock, and drives the TX output mux select (idle/start/data/
//  parity/stop). It also drives the load/shift strobes of the serializer.
//  It sits between the register/sys-control layer (data_valid, par_en) and the
//  serializer + parity calculator + output mux of UART_TX.
// PARAMETERS
//  DATA_WIDTH   8   data bits per frame, 1..16; bit_idx width = $clog2(DATA_WIDTH)
//  CLKS_PER_BIT 16  CLK cycles per serial bit, >=2
//  STOP_BITS    1   number of stop bits, 1 or 2
// PORTS
//  CLK        in   1  system clock, all logic on posedge
//  RST        in   1  synchronous active-low reset
//  data_valid in   1  frame request; serializer data/parity are valid while high
//  par_en     in   1  1 = send parity bit; sampled only when a frame is accepted
//  load       out  1  1-cycle pulse: serializer captures parallel data, presents bit 0
//  ser_en     out  1  1-cycle pulse: serializer shifts to next data bit
//  bit_idx    out  $clog2(DATA_WIDTH)  index of data bit currently on the line
//  mux_sel    out  3  000 idle, 001 start, 010 ser_data, 011 par_bit, 100 stop
//  busy       out  1  high from the cycle after acceptance until frame end
//  done       out  1  1-cycle pulse on the last cycle of the final stop bit
// BEHAVIOUR
//  - States: IDLE, START, DATA, PARITY, STOP. mux_sel and busy are decoded from the
//    registered state. busy = (state != IDLE).
//  - Reset (RST low at posedge): state=IDLE, baud cnt=0, bit_idx=0, stop cnt=0,
//    par latch=0. Outputs after that edge: mux_sel=000, busy=0, load=0, ser_en=0,
//    done=0. Line returns to idle-high within 1 cycle, even mid-frame.
//    No partial frame resumes.
//  - Baud counter: counts 0..CLKS_PER_BIT-1 in every non-IDLE state.
//    bit_end = (cnt == CLKS_PER_BIT-1). cnt clears on acceptance and wraps at bit_end.
//  - Accept: if state==IDLE and data_valid=1 at edge N, then:
//      load=1 during cycle N (combinational on IDLE & data_valid);
//      par_en is latched;
//      state=START, mux_sel=001 from cycle N+1.
//  - START --bit_end--> DATA, bit_idx=0.
//  - DATA at bit_end: if bit_idx<DATA_WIDTH-1, assert ser_en=1 that cycle and bit_idx++.
//    Otherwise go to PARITY if the par latch is set, else to STOP. No ser_en after the
//    last bit.
//  - PARITY --bit_end--> STOP.
//  - STOP lasts STOP_BITS full bit periods; the stop counter resets on entry.
//  - At the final bit_end of STOP: done=1.
//      If data_valid=1 the same cycle: back-to-back accept (load=1, latch par_en,
//      next state START, cnt=0, no idle gap).
//      Else next state IDLE.
//  - data_valid in any other non-IDLE cycle is ignored (not queued). The requester holds
//    it until it sees load.
//  - par_en changes mid-frame have no effect on the current frame.
//  - Frame length = (1 + DATA_WIDTH + par + STOP_BITS) * CLKS_PER_BIT cycles, exact.
//    Every bit, including start, lasts exactly CLKS_PER_BIT cycles.
//  - Illegal/unreached state encodings recover to IDLE on the next edge. mux_sel
//    decodes them as 000.
// TESTING
//  1. Reset: hold RST=0 for 3 cycles with data_valid=1
//     -> mux_sel=000, busy=0, load=0, done=0 throughout.
//  2. Defaults, par_en=0, data_valid pulse at cycle 10 -> load at 10; mux_sel=001 cycles
//     11-26; 010 cycles 27-154 with ser_en at 42,58,...,138 (7 pulses); 100 cycles
//     155-170; done at 170; IDLE at 171.
//  3. par_en=1, same stimulus -> mux_sel=011 for cycles 155-170, stop 171-186, done at
//     186. Frame is 176 cycles.
//  4. data_valid held high continuously -> second load coincides with first done;
//     mux_sel goes 100->001 with no 000 cycle.
//  5. RST=0 for one cycle while in DATA at bit_idx=3 -> next cycle mux_sel=000, bit_idx=0,
//     busy=0. A later request sends a full, correct frame.
//  6. STOP_BITS=2, CLKS_PER_BIT=4, DATA_WIDTH=5 -> stop held 8 cycles, frame 32 cycles;
//     toggling par_en mid-frame does not alter the sequence.

Source files
------------

// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if: request and serializer-strobe bundle between sys-control, the sequencer and the serializer
interface uart_tx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    localparam int IW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
    logic          data_valid;
    logic          par_en;
    logic          load;
    logic          ser_en;
    logic [IW-1:0] bit_idx;
    logic [2:0]    mux_sel;
    logic          busy;
    logic          done;
    modport master (output data_valid, par_en, input load, ser_en, bit_idx, mux_sel, busy, done);
    modport slave  (input data_valid, par_en, output load, ser_en, bit_idx, mux_sel, busy, done);
endinterface

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART frame sequencer driving bit timing, serializer strobes and the TX mux select
module uart_tx_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input logic          CLK,
    input logic          RST,
    uart_tx_ctrl_if.slave bus
);
    localparam int IW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
    localparam int CW = $clog2(CLKS_PER_BIT);
    typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4} state_t;
    state_t        state_q, state_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [IW-1:0] idx_q, idx_n;
    logic          stop_q, stop_n;
    logic          par_q, par_n;
    logic          load, ser_en, done;
    logic          bit_end, last_bit, last_stop;
    assign bit_end   = cnt_q == CW'(CLKS_PER_BIT - 1);
    assign last_bit  = idx_q == IW'(DATA_WIDTH - 1);
    assign last_stop = stop_q == 1'(STOP_BITS - 1);
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            idx_q   <= idx_n;
            stop_q  <= stop_n;
            par_q   <= par_n;
        end
    end
    // load is gated by RST so a request held through reset is not acknowledged
    always_comb begin
        state_n = state_q;
        cnt_n   = bit_end ? '0 : cnt_q + 1'b1;
        idx_n   = '0;
        stop_n  = 1'b0;
        par_n   = par_q;
        load    = 1'b0;
        ser_en  = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_n = '0;
                if (bus.data_valid) begin
                    load    = RST;
                    par_n   = bus.par_en;
                    state_n = START;
                end
            end
            START: state_n = bit_end ? DATA : START;
            DATA: begin
                idx_n = idx_q;
                if (bit_end && !last_bit) begin
                    ser_en = 1'b1;
                    idx_n  = idx_q + 1'b1;
                end else if (bit_end) begin
                    idx_n   = '0;
                    state_n = par_q ? PARITY : STOP;
                end
            end
            PARITY: state_n = bit_end ? STOP : PARITY;
            STOP: begin
                stop_n = bit_end ? stop_q + 1'b1 : stop_q;
                if (bit_end && last_stop) begin
                    done    = 1'b1;
                    stop_n  = 1'b0;
                    state_n = IDLE;
                    if (bus.data_valid) begin
                        load    = RST;
                        par_n   = bus.par_en;
                        state_n = START;
                    end
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end
    assign bus.load    = load;
    assign bus.ser_en  = ser_en;
    assign bus.done    = done;
    assign bus.bit_idx = idx_q;
    assign bus.busy    = state_q != IDLE;
    assign bus.mux_sel = state_q == START  ? 3'b001 :
                         state_q == DATA   ? 3'b010 :
                         state_q == PARITY ? 3'b011 :
                         state_q == STOP   ? 3'b100 : 3'b000;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: per-cycle scoreboard for two sequencer configurations (8/16/1 and 5/4/2)
module tb_uart_tx_ctrl;
    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   checks = 0;
    int   errors = 0;
    always #5 CLK = ~CLK;
    typedef struct packed {
        logic [2:0] mux;
        logic       ser_en;
        logic       done;
        logic [3:0] idx;
    } exp_t;
    exp_t q[2][$];
    uart_tx_ctrl_if #(.DATA_WIDTH(8)) ia ();
    uart_tx_ctrl_if #(.DATA_WIDTH(5)) ib ();
    uart_tx_ctrl #(.DATA_WIDTH(8), .CLKS_PER_BIT(16), .STOP_BITS(1)) dut_a (.CLK(CLK), .RST(RST), .bus(ia));
    uart_tx_ctrl #(.DATA_WIDTH(5), .CLKS_PER_BIT(4),  .STOP_BITS(2)) dut_b (.CLK(CLK), .RST(RST), .bus(ib));
    logic [2:0] o_mux [2];
    logic [3:0] o_idx [2];
    logic       o_ser [2];
    logic       o_done[2];
    logic       o_load[2];
    logic       o_busy[2];
    logic       o_dv  [2];
    logic       o_par [2];
    assign o_mux[0]  = ia.mux_sel;
    assign o_mux[1]  = ib.mux_sel;
    assign o_idx[0]  = 4'(ia.bit_idx);
    assign o_idx[1]  = 4'(ib.bit_idx);
    assign o_ser[0]  = ia.ser_en;
    assign o_ser[1]  = ib.ser_en;
    assign o_done[0] = ia.done;
    assign o_done[1] = ib.done;
    assign o_load[0] = ia.load;
    assign o_load[1] = ib.load;
    assign o_busy[0] = ia.busy;
    assign o_busy[1] = ib.busy;
    assign o_dv[0]   = ia.data_valid;
    assign o_dv[1]   = ib.data_valid;
    assign o_par[0]  = ia.par_en;
    assign o_par[1]  = ib.par_en;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask
    // expected outputs for cycle k of a frame, counted from the first START cycle
    function automatic exp_t frame_at(int k, bit par, int dw, int cpb, int sb);
        exp_t e = '0;
        int   b = k / cpb;
        bit   last = (k % cpb) == cpb - 1;
        if (b == 0) e.mux = 3'b001;
        else if (b <= dw) begin
            e.mux    = 3'b010;
            e.idx    = 4'(b - 1);
            e.ser_en = last && (b - 1 < dw - 1);
        end else if (par && b == dw + 1) e.mux = 3'b011;
        else begin
            e.mux  = 3'b100;
            e.done = k == (1 + dw + int'(par) + sb) * cpb - 1;
        end
        return e;
    endfunction
    always @(negedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            exp_t cur;
            bit   acc;
            int   dw, cpb, sb;
            dw  = i == 0 ? 8 : 5;
            cpb = i == 0 ? 16 : 4;
            sb  = i == 0 ? 1 : 2;
            cur = '0;
            if (q[i].size() > 0) cur = q[i].pop_front();
            acc = RST && o_dv[i] && (cur.mux == 3'b000 || cur.done);
            check($sformatf("mux_sel%0d", i), 32'(o_mux[i]), 32'(cur.mux));
            check($sformatf("busy%0d", i), 32'(o_busy[i]), 32'(cur.mux != 3'b000));
            check($sformatf("ser_en%0d", i), 32'(o_ser[i]), 32'(cur.ser_en));
            check($sformatf("done%0d", i), 32'(o_done[i]), 32'(cur.done));
            check($sformatf("bit_idx%0d", i), 32'(o_idx[i]), 32'(cur.idx));
            check($sformatf("load%0d", i), 32'(o_load[i]), 32'(acc));
            if (!RST) q[i].delete();
            else if (acc)
                for (int k = 0; k < (1 + dw + int'(o_par[i]) + sb) * cpb; k++)
                    q[i].push_back(frame_at(k, o_par[i], dw, cpb, sb));
        end
    end
    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask
    initial begin
        ia.data_valid = 1'b1;
        ia.par_en     = 1'b0;
        ib.data_valid = 1'b1;
        ib.par_en     = 1'b0;
        cyc(3);
        RST           = 1'b1;
        ia.data_valid = 1'b0;
        ib.data_valid = 1'b0;
        cyc(10);
        ia.data_valid = 1'b1;
        cyc(1);
        ia.data_valid = 1'b0;
        cyc(180);
        ia.par_en     = 1'b1;
        ia.data_valid = 1'b1;
        cyc(1);
        ia.data_valid = 1'b0;
        cyc(50);
        ia.par_en = 1'b0;
        cyc(140);
        ia.data_valid = 1'b1;
        cyc(500);
        ia.data_valid = 1'b0;
        cyc(200);
        // reset lands while bit 3 is on the line
        ia.data_valid = 1'b1;
        cyc(1);
        ia.data_valid = 1'b0;
        cyc(69);
        RST = 1'b0;
        cyc(1);
        RST = 1'b1;
        cyc(20);
        ia.data_valid = 1'b1;
        cyc(1);
        ia.data_valid = 1'b0;
        cyc(200);
        for (int f = 0; f < 2; f++) begin
            ib.par_en     = f[0];
            ib.data_valid = 1'b1;
            cyc(1);
            ib.data_valid = 1'b0;
            for (int t = 0; t < 15; t++) begin
                ib.par_en = ~ib.par_en;
                cyc(3);
            end
        end
        ib.data_valid = 1'b1;
        for (int t = 0; t < 40; t++) begin
            ib.par_en = t[2];
            cyc(3);
        end
        ib.data_valid = 1'b0;
        cyc(60);
        check("drain0", 32'(q[0].size()), 32'd0);
        check("drain1", 32'(q[1].size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
